// File: rtl/util_axis_puf_pkg.sv
// ============================================================================
// Module   : util_axis_puf_pkg
// Brief    : Command codes and sequencer state encoding shared by the PUF
//            string decoder and util_axis_puf_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package util_axis_puf_pkg;

    localparam logic [3:0] CMD_SELA  = 4'h1;
    localparam logic [3:0] CMD_SELB  = 4'h2;
    localparam logic [3:0] CMD_START = 4'h3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SEND  = 2'd3
    } puf_state_e;

endpackage : util_axis_puf_pkg

`default_nettype wire

// File: rtl/util_axis_puf_timeout.sv
// ============================================================================
// Module   : util_axis_puf_timeout
// Brief    : WAIT-state watchdog; expired_o flags the last allowed WAIT cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module util_axis_puf_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int         CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CNT_LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Count holds the number of WAIT cycles already elapsed, so the match is the final one.
    assign expired_o = en_i && (count_q == CNT_LAST);

endmodule : util_axis_puf_timeout

`default_nettype wire

// File: rtl/util_axis_puf_sequencer.sv
// ============================================================================
// Module   : util_axis_puf_sequencer
// Brief    : Sequences SELA/SELB/START commands into a PUF challenge and
//            returns the response (or an error) on an AXI-Stream master.
//            Optional WAIT timeout enabled by macro PUF_SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module util_axis_puf_sequencer
    import util_axis_puf_pkg::*;
#(
    parameter int RESP_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  aclk,
    input  logic                  arstn,
    input  logic [7:0]            s_axis_tdata,
    input  logic [3:0]            s_axis_tuser,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [7:0]            puf_sel_a,
    output logic [7:0]            puf_sel_b,
    output logic                  puf_start,
    input  logic                  puf_done,
    input  logic [RESP_WIDTH-1:0] puf_resp,
    output logic [RESP_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    if ((RESP_WIDTH < 1) || (RESP_WIDTH > 32)) begin : g_resp_width_check
        $error("RESP_WIDTH must be in 1..32");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    puf_state_e            state_q, state_d;
    logic [7:0]            sel_a_q, sel_a_d;
    logic [7:0]            sel_b_q, sel_b_d;
    logic                  loaded_a_q, loaded_a_d;
    logic                  loaded_b_q, loaded_b_d;
    logic [RESP_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tuser_q, tuser_d;
    logic                  tvalid_q;
    logic                  tready_q;
    logic                  start_q;

    logic                  w_accept;
    logic                  w_timeout;

    assign w_accept = s_axis_tvalid && tready_q;

`ifdef PUF_SEQ_TIMEOUT_EN
    util_axis_puf_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (aclk),
        .rst_ni    (arstn),
        .clear_i   (state_q == ST_START),
        .en_i      (state_q == ST_WAIT),
        .expired_o (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        sel_a_d    = sel_a_q;
        sel_b_d    = sel_b_q;
        loaded_a_d = loaded_a_q;
        loaded_b_d = loaded_b_q;
        tdata_d    = tdata_q;
        tuser_d    = tuser_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    case (s_axis_tuser)
                        CMD_SELA: begin
                            sel_a_d    = s_axis_tdata;
                            loaded_a_d = 1'b1;
                        end
                        CMD_SELB: begin
                            sel_b_d    = s_axis_tdata;
                            loaded_b_d = 1'b1;
                        end
                        CMD_START: begin
                            if (loaded_a_q && loaded_b_q) begin
                                state_d = ST_START;
                            end else begin
                                state_d = ST_SEND;
                                tdata_d = '0;
                                tuser_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                // A done strobe on the timeout cycle still delivers the real response.
                if (puf_done) begin
                    state_d = ST_SEND;
                    tdata_d = puf_resp;
                    tuser_d = 1'b0;
                end else if (w_timeout) begin
                    state_d = ST_SEND;
                    tdata_d = '0;
                    tuser_d = 1'b1;
                end
            end
            ST_SEND: begin
                if (m_axis_tready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake flags are registered so that they all read zero while arstn is low.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q    <= ST_IDLE;
            sel_a_q    <= '0;
            sel_b_q    <= '0;
            loaded_a_q <= 1'b0;
            loaded_b_q <= 1'b0;
            tdata_q    <= '0;
            tuser_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            tready_q   <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_a_q    <= sel_a_d;
            sel_b_q    <= sel_b_d;
            loaded_a_q <= loaded_a_d;
            loaded_b_q <= loaded_b_d;
            tdata_q    <= tdata_d;
            tuser_q    <= tuser_d;
            tvalid_q   <= (state_d == ST_SEND);
            tready_q   <= (state_d == ST_IDLE);
            start_q    <= (state_d == ST_START);
        end
    end

    assign s_axis_tready = tready_q;
    assign puf_sel_a     = sel_a_q;
    assign puf_sel_b     = sel_b_q;
    assign puf_start     = start_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;

endmodule : util_axis_puf_sequencer

`default_nettype wire
